// File: rtl/ar_pkg.sv
// Shared ARINC-429 word geometry and the odd-parity helper used by the RX path.
package ar_pkg;
  localparam int AR_LBL_W   = 8;
  localparam int AR_DAT_W   = 24;
  localparam int AR_WORD_W  = 32;
  localparam int AR_PAR_BIT = 23;

  function automatic logic ar_par_ok(input logic [AR_WORD_W-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/ar_fifo_mem.sv
// Simple dual-port word array: synchronous write, combinational read for FWFT.
module ar_fifo_mem
  import ar_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [AR_WORD_W-1:0] wd,
  input  logic [AW-1:0]        ra,
  output logic [AR_WORD_W-1:0] rdata
);
  logic [AR_WORD_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  assign rdata = mem_q[ra];
endmodule

// File: rtl/ar_rx_fifo.sv
// ARINC-429 receive buffer: parity check, label filter, FWFT queue and
// sticky/saturating link statistics.
module ar_rx_fifo
  import ar_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit PAR_DROP   = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  ce_wr,
  input  logic [AR_LBL_W-1:0]   sr_adr,
  input  logic [AR_DAT_W-1:0]   sr_dat,
  input  logic                  flt_en,
  input  logic [AR_LBL_W-1:0]   flt_lbl,
  input  logic                  rd,
  output logic [AR_LBL_W-1:0]   RX_ADR,
  output logic [AR_DAT_W-1:0]   RX_DAT,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic [CNT_W-1:0]      n_perr,
  output logic [CNT_W-1:0]      n_drop
);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]      n_perr_q, n_perr_d, n_drop_q, n_drop_d;
  logic [AR_WORD_W-1:0]  wr_word, head;
  logic                  par_ok, reject, qual, do_wr, do_rd, ovf_evt, rej_evt;

  assign wr_word = {sr_dat, sr_adr};
  assign par_ok  = ar_par_ok(wr_word);
  assign reject  = flt_en && (sr_adr != flt_lbl);
  assign qual    = ce_wr && !reject && (par_ok || !PAR_DROP);
  // A full FIFO still accepts when the same edge pops, so rd frees the slot.
  assign do_wr   = qual && (!full_q || rd);
  assign do_rd   = rd && !empty_q;
  assign ovf_evt = qual && full_q && !rd;
  // A parity-dropped word is charged to n_perr only, never also to n_drop.
  assign rej_evt = ce_wr && reject && (par_ok || !PAR_DROP);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q || ovf_evt;
    n_perr_d = n_perr_q;
    n_drop_d = n_drop_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = level_d[DEPTH_LOG2];
    if (ce_wr && !par_ok && n_perr_q != '1) n_perr_d = n_perr_q + CNT_ONE;
    if ((ovf_evt || rej_evt) && n_drop_q != '1) n_drop_d = n_drop_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      n_perr_q <= '0;
      n_drop_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      n_perr_q <= n_perr_d;
      n_drop_q <= n_drop_d;
    end
  end

  ar_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (do_wr && !R),
    .wa    (wr_ptr_q),
    .wd    (wr_word),
    .ra    (rd_ptr_q),
    .rdata (head)
  );

  // Memory is never cleared, so the head is masked to zero while empty.
  assign RX_ADR = empty_q ? '0 : head[AR_LBL_W-1:0];
  assign RX_DAT = empty_q ? '0 : head[AR_WORD_W-1:AR_LBL_W];
  assign empty  = empty_q;
  assign full   = full_q;
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign n_perr = n_perr_q;
  assign n_drop = n_drop_q;
endmodule

// File: tb/tb_ar_rx_fifo.sv
// Directed bench for ar_rx_fifo (DEPTH_LOG2=4, PAR_DROP=1, CNT_W=8).
module tb_ar_rx_fifo;
  import ar_pkg::*;

  logic        clk = 1'b0;
  logic        R, ce_wr, flt_en, rd;
  logic [7:0]  sr_adr, flt_lbl, RX_ADR, n_perr, n_drop;
  logic [23:0] sr_dat, RX_DAT, bad_dat;
  logic        empty, full, ovf;
  logic [4:0]  level;
  int          n_cmp = 0, n_mis = 0;

  always #5 clk = ~clk;

  ar_rx_fifo dut (
    .clk(clk), .R(R), .ce_wr(ce_wr), .sr_adr(sr_adr), .sr_dat(sr_dat),
    .flt_en(flt_en), .flt_lbl(flt_lbl), .rd(rd), .RX_ADR(RX_ADR),
    .RX_DAT(RX_DAT), .empty(empty), .full(full), .level(level), .ovf(ovf),
    .n_perr(n_perr), .n_drop(n_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic ce, input logic [7:0] a, input logic [23:0] d, input logic r);
    ce_wr = ce; sr_adr = a; sr_dat = d; rd = r;
    @(posedge clk); #1;
    ce_wr = 1'b0; rd = 1'b0;
  endtask

  // Data field with bit 23 chosen so the full 32-bit word has odd parity.
  function automatic logic [23:0] good(input logic [7:0] a, input logic [22:0] d);
    return {~^{d, a}, d};
  endfunction

  task automatic do_reset();
    R = 1'b1; step(1'b0, 8'h00, 24'h0, 1'b0); R = 1'b0;
  endtask

  initial begin
    R = 1'b1; ce_wr = 0; rd = 0; flt_en = 0; flt_lbl = 8'h00; sr_adr = 0; sr_dat = 0;
    bad_dat = 24'h812345;
    bad_dat[AR_PAR_BIT] = ~bad_dat[AR_PAR_BIT];
    step(1'b0, 8'h00, 24'h0, 1'b0);
    step(1'b0, 8'h00, 24'h0, 1'b0);
    R = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_nperr", 32'(n_perr), 0);
    chk("rst_ndrop", 32'(n_drop), 0);
    chk("rst_adr",   32'(RX_ADR), 0);
    chk("rst_dat",   32'(RX_DAT), 0);

    // Good word becomes visible one cycle after the strobe.
    step(1'b1, 8'h2A, 24'h812345, 1'b0);
    chk("wr_empty", 32'(empty), 0);
    chk("wr_adr",   32'(RX_ADR), 'h2A);
    chk("wr_dat",   32'(RX_DAT), 'h812345);
    chk("wr_level", 32'(level), 1);

    // Parity-flipped copy is counted and dropped.
    step(1'b1, 8'h2A, bad_dat, 1'b0);
    chk("perr_cnt",   32'(n_perr), 1);
    chk("perr_level", 32'(level), 1);
    chk("perr_dat",   32'(RX_DAT), 'h812345);
    chk("perr_ndrop", 32'(n_drop), 0);

    step(1'b0, 8'h00, 24'h0, 1'b1);
    chk("pop_empty", 32'(empty), 1);
    chk("pop_dat",   32'(RX_DAT), 0);
    step(1'b0, 8'h00, 24'h0, 1'b1);
    chk("rd_on_empty", 32'(level), 0);
    step(1'b1, 8'h2A, 24'h812345, 1'b1);
    chk("rdwr_empty_level", 32'(level), 1);
    step(1'b0, 8'h00, 24'h0, 1'b1);

    // Label filter: 2A, 31, 2A.
    flt_en = 1'b1; flt_lbl = 8'h2A;
    step(1'b1, 8'h2A, 24'h812345, 1'b0);
    step(1'b1, 8'h31, 24'h812345, 1'b0);
    step(1'b1, 8'h2A, 24'h812345, 1'b0);
    chk("flt_level", 32'(level), 2);
    chk("flt_ndrop", 32'(n_drop), 1);
    chk("flt_ovf",   32'(ovf), 0);
    chk("flt_adr",   32'(RX_ADR), 'h2A);
    flt_en = 1'b0;

    // Fill 16, overflow on 17, then drain in order.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), good(8'(i), 23'(i * 7 + 100)), 1'b0);
      if (i == 15) chk("fill15_full", 32'(full), 0);
    end
    chk("fill16_full",  32'(full), 1);
    chk("fill16_level", 32'(level), 16);
    step(1'b1, 8'h11, good(8'h11, 23'h1), 1'b0);
    chk("ovf_set",   32'(ovf), 1);
    chk("ovf_ndrop", 32'(n_drop), 1);
    chk("ovf_level", 32'(level), 16);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_adr%0d", i), 32'(RX_ADR), 32'(i));
      chk($sformatf("drain_dat%0d", i), 32'(RX_DAT), 32'(good(8'(i), 23'(i * 7 + 100))));
      step(1'b0, 8'h00, 24'h0, 1'b1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_dat0",  32'(RX_DAT), 0);

    // Full with simultaneous write and read.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(8'h50 + i), good(8'(8'h50 + i), 23'(i)), 1'b0);
    step(1'b1, 8'h77, good(8'h77, 23'h5), 1'b1);
    chk("fullrw_level", 32'(level), 16);
    chk("fullrw_full",  32'(full), 1);
    chk("fullrw_ovf",   32'(ovf), 1);
    chk("fullrw_ndrop", 32'(n_drop), 1);
    chk("fullrw_head",  32'(RX_ADR), 'h52);

    // Mid-stream reset at level 5 with ovf set; strobes in the reset cycle ignored.
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 24'h0, 1'b1);
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_ovf",   32'(ovf), 1);
    R = 1'b1; step(1'b1, 8'h2A, 24'h812345, 1'b1); R = 1'b0;
    chk("mrst_level", 32'(level), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_full",  32'(full), 0);
    chk("mrst_ovf",   32'(ovf), 0);
    chk("mrst_nperr", 32'(n_perr), 0);
    chk("mrst_ndrop", 32'(n_drop), 0);
    chk("mrst_dat",   32'(RX_DAT), 0);

    // Parity counter saturation.
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 8'h2A, bad_dat, 1'b0);
      if (i == 254) chk("perr_254", 32'(n_perr), 254);
      if (i == 255) chk("perr_255", 32'(n_perr), 255);
    end
    chk("perr_sat",       32'(n_perr), 255);
    chk("perr_sat_level", 32'(level), 0);
    chk("perr_sat_ndrop", 32'(n_drop), 0);

    // Bad parity plus filter reject charges n_perr only.
    flt_en = 1'b1; flt_lbl = 8'h2A;
    step(1'b1, 8'h31, 24'h012345, 1'b0);
    chk("perr_rej_ndrop", 32'(n_drop), 0);
    chk("perr_rej_level", 32'(level), 0);
    flt_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
